// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub (with bit cell fas)
// Purpose  : Bit-serial W-bit add/subtract sequencer driving one fas cell,
//            LSB first, with carry/borrow and signed-overflow flags.
// Revision : 1.0 - initial release
// ============================================================================

module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    // Add: majority carry. Subtract: borrow of a - b - cin.
    assign cout = a_ns ? ((a & b) | (a & cin) | (b & cin))
                       : ((~a & b) | (~a & cin) | (b & cin));
endmodule

module serial_addsub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         a_ns,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         ovf
);
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0]     r_sa;
    logic [W-1:0]     r_sb;
    // Only the upper W-1 result bits are kept; bit 0 would be shifted out
    // on the completing edge anyway.
    logic [W-2:0]     r_sr;
    logic             r_c;
    logic             r_op;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic [W-1:0]     w_sr_next;
    logic             w_ovf;

    fas u_fas (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_c),
        .a_ns (r_op),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_accept  = (r_state != S_RUN) && start;
    assign w_last    = (r_state == S_RUN) && (r_cnt == C_LAST);
    assign w_sr_next = {w_s, r_sr};
    assign w_ovf     = r_op ? ((r_a_msb == r_b_msb) && (w_s != r_a_msb))
                            : ((r_a_msb != r_b_msb) && (w_s != r_a_msb));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                ready = 1'b0;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_sr    <= '0;
            r_c     <= 1'b0;
            r_op    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            result  <= '0;
            carry   <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= op_a;
            r_sb    <= op_b;
            r_op    <= a_ns;
            r_a_msb <= op_a[W-1];
            r_b_msb <= op_b[W-1];
            r_c     <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_sa  <= {1'b0, r_sa[W-1:1]};
            r_sb  <= {1'b0, r_sb[W-1:1]};
            r_sr  <= w_sr_next[W-1:1];
            r_c   <= w_cout;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                result <= w_sr_next;
                carry  <= w_cout;
                ovf    <= w_ovf;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub
// Purpose  : Directed + random scoreboard bench for serial_addsub (W=8, W=5).
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_addsub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, a_ns;
    logic [7:0] op_a, op_b, result;
    logic       ready, done, carry, ovf;
    logic       start5, a_ns5;
    logic [4:0] op_a5, op_b5, result5;
    logic       ready5, done5, carry5, ovf5;

    int total = 0;
    int bad   = 0;
    logic [9:0] q8[$];
    logic [9:0] q5[$];

    always #5 clk = ~clk;

    serial_addsub #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_ns(a_ns),
        .op_a(op_a), .op_b(op_b), .ready(ready), .done(done),
        .result(result), .carry(carry), .ovf(ovf)
    );

    serial_addsub #(.W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .a_ns(a_ns5),
        .op_a(op_a5), .op_b(op_b5), .ready(ready5), .done(done5),
        .result(result5), .carry(carry5), .ovf(ovf5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, carry, result[7:0]} for a w-bit operation.
    function automatic logic [9:0] model(input int w, input int a, input int b, input bit add);
        int mask, res, c, am, bm, rm, o;
        mask = (1 << w) - 1;
        if (add) begin
            res = (a + b) & mask;
            c   = ((a + b) >> w) & 1;
        end else begin
            res = (a - b) & mask;
            c   = (a < b) ? 1 : 0;
        end
        am = (a >> (w - 1)) & 1;
        bm = (b >> (w - 1)) & 1;
        rm = (res >> (w - 1)) & 1;
        if (add) o = (am == bm && rm != am) ? 1 : 0;
        else     o = (am != bm && rm != am) ? 1 : 0;
        return {o[0], c[0], res[7:0]};
    endfunction

    // Called at a negedge where the DUT is ready; returns at the negedge after accept.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic add, input bit push);
        start = 1'b1; op_a = a; op_b = b; a_ns = add;
        if (push) q8.push_back(model(8, a, b, add));
        @(negedge clk);
        start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); a_ns = 1'($urandom);
    endtask

    task automatic finish8(input string tag, input int n0, input int lat);
        int n;
        logic [9:0] e;
        n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_q_nonempty"}, (q8.size() != 0), 1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            chk({tag, "_result"}, result, e[7:0]);
            chk({tag, "_carry"}, carry, e[8]);
            chk({tag, "_ovf"}, ovf, e[9]);
        end
    endtask

    initial begin
        int n, cnt;
        logic [9:0] e;
        logic [7:0] ra, rb;
        logic       rop;
        start = 0; a_ns = 0; op_a = 0; op_b = 0;
        start5 = 0; a_ns5 = 0; op_a5 = 0; op_b5 = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry, ovf}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue8(8'h3C, 8'h55, 1'b1, 1);
        chk("run_ready", ready, 0);
        finish8("add_3c_55", 0, 8);
        chk("add_result_const", result, 8'h91);
        chk("add_flags_const", {carry, ovf}, 2'b01);
        @(negedge clk);
        chk("done_pulse_one", done, 0);
        chk("idle_ready", ready, 1);

        issue8(8'hFF, 8'h01, 1'b1, 1); finish8("add_wrap", 0, 8);
        chk("wrap_const", {ovf, carry, result}, {1'b0, 1'b1, 8'h00});
        @(negedge clk);
        issue8(8'h00, 8'h01, 1'b0, 1); finish8("sub_0_1", 0, 8);
        chk("sub01_const", {ovf, carry, result}, {1'b0, 1'b1, 8'hFF});
        @(negedge clk);
        issue8(8'h80, 8'h01, 1'b0, 1); finish8("sub_80_1", 0, 8);
        chk("sub80_const", {ovf, carry, result}, {1'b1, 1'b0, 8'h7F});
        @(negedge clk);
        issue8(8'h10, 8'h01, 1'b0, 1); finish8("sub_10_1", 0, 8);

        // Back-to-back: second request presented in the done cycle.
        @(negedge clk);
        issue8(8'h3C, 8'h55, 1'b1, 1); finish8("b2b_first", 0, 8);
        issue8(8'h22, 8'h33, 1'b0, 1);
        @(negedge clk); @(negedge clk);
        start = 1'b1; op_a = 8'hAA; op_b = 8'hAA; a_ns = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_hold_result", result, 8'h91);
        chk("b2b_ignored_start", done, 0);
        finish8("b2b_second", 3, 8);
        chk("b2b_second_const", result, 8'hEF);

        // Reset in the middle of an operation.
        @(negedge clk);
        issue8(8'h3C, 8'h55, 1'b1, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {done, carry, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        issue8(8'h01, 8'h02, 1'b1, 1); finish8("after_rst", 0, 8);
        chk("after_rst_const", result, 8'h03);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ra = 8'($urandom); rb = 8'($urandom); rop = 1'($urandom);
            if (i == 0) begin ra = 8'h7F; rb = 8'h01; rop = 1'b1; end
            if (i == 1) begin ra = 8'h7F; rb = 8'hFF; rop = 1'b0; end
            issue8(ra, rb, rop, 1);
            finish8("rand8", 0, 8);
        end

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ra = 8'($urandom_range(0, 31)); rb = 8'($urandom_range(0, 31)); rop = 1'($urandom);
            if (i == 0) begin ra = 8'h10; rb = 8'h01; rop = 1'b0; end
            chk("rand5_ready", ready5, 1);
            start5 = 1'b1; op_a5 = ra[4:0]; op_b5 = rb[4:0]; a_ns5 = rop;
            q5.push_back(model(5, int'(ra), int'(rb), rop));
            @(negedge clk);
            start5 = 1'b0; op_a5 = 5'($urandom); op_b5 = 5'($urandom);
            n = 0;
            while (!done5 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("rand5_latency", n, 5);
            if (q5.size() != 0) begin
                e = q5.pop_front();
                chk("rand5_result", result5, {3'b000, e[4:0]});
                chk("rand5_carry", carry5, e[8]);
                chk("rand5_ovf", ovf5, e[9]);
            end
        end

        chk("q8_drained", q8.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
